// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ requesters.
// Latency: accept at N -> AW/W or AR at N+1 -> slave response at N+2 (earliest) -> rsp_valid at N+3.
// Backpressure: req_ready only in IDLE for the winner; rsp_valid is a one-cycle pulse with no backpressure.
//
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   req_valid/ready/we           per-requester command handshake and direction (1 = write)
//   req_addr/wdata/wstrb         packed per-requester command fields, slice i belongs to requester i
//   rsp_valid/rdata/resp         response pulse to the granted requester; rdata/resp hold until next response
//   busy                         high whenever a transaction is in flight
//   M_AXI_*                      AXI4-Lite master (single outstanding transaction)
module axil_req_arbiter #(
    parameter int         NUM_REQ = 2,
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [2:0] PROT    = 3'b000
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic                       busy,
    output logic [ADDR_W-1:0]          M_AXI_AWADDR,
    output logic [2:0]                 M_AXI_AWPROT,
    output logic                       M_AXI_AWVALID,
    input  logic                       M_AXI_AWREADY,
    output logic [DATA_W-1:0]          M_AXI_WDATA,
    output logic [DATA_W/8-1:0]        M_AXI_WSTRB,
    output logic                       M_AXI_WVALID,
    input  logic                       M_AXI_WREADY,
    input  logic [1:0]                 M_AXI_BRESP,
    input  logic                       M_AXI_BVALID,
    output logic                       M_AXI_BREADY,
    output logic [ADDR_W-1:0]          M_AXI_ARADDR,
    output logic [2:0]                 M_AXI_ARPROT,
    output logic                       M_AXI_ARVALID,
    input  logic                       M_AXI_ARREADY,
    input  logic [DATA_W-1:0]          M_AXI_RDATA,
    input  logic [1:0]                 M_AXI_RRESP,
    input  logic                       M_AXI_RVALID,
    output logic                       M_AXI_RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int GNT_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WR_B = 3'd2,
        S_RD_A = 3'd3,
        S_RD_R = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [GNT_W-1:0]     last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;

    logic                 win_found;
    logic [GNT_W-1:0]     win_idx;
    logic [GNT_W-1:0]     cand_idx;
    int                   cand;
    logic                 aw_hs, w_hs;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = GNT_W'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Grant is combinational so a requester is accepted in the cycle it asks.
    always_comb begin
        req_ready = '0;
        if (!ARESET && state_q == S_IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q & M_AXI_WREADY;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    last_grant_d = win_idx;
                    addr_d       = req_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d      = req_wdata[win_idx*DATA_W +: DATA_W];
                    wstrb_d      = req_wstrb[win_idx*STRB_W +: STRB_W];
                    if (req_we[win_idx]) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently; the done flags remember
                // whichever finished first.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = S_WR_B;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_WR_B: begin
                // Stay here during the rsp_valid pulse so no grant overlaps it.
                if (rsp_valid_q != '0) begin
                    state_d = S_IDLE;
                end else if (bready_q && M_AXI_BVALID) begin
                    bready_d                  = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = '0;
                    rsp_resp_d                = M_AXI_BRESP;
                end
            end
            S_RD_A: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (rsp_valid_q != '0) begin
                    state_d = S_IDLE;
                end else if (rready_q && M_AXI_RVALID) begin
                    rready_d                  = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = M_AXI_RDATA;
                    rsp_resp_d                = M_AXI_RRESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_W'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
